// File: rtl/dispatcher_pkg.sv
// Shared opcode encodings, widths and opcode-class helpers
// for the Tomasulo issue stage.
package dispatcher_pkg;

   localparam int ROB_W  = 4;
   localparam int ID_W   = 32;
   localparam int ADDR_W = 32;
   localparam int OP_W   = 6;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 6'd0,
      OP_LUI   = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL   = 6'd3,
      OP_JALR  = 6'd4,
      OP_BEQ   = 6'd5,
      OP_BNE   = 6'd6,
      OP_BLT   = 6'd7,
      OP_BGE   = 6'd8,
      OP_BLTU  = 6'd9,
      OP_BGEU  = 6'd10,
      OP_LB    = 6'd11,
      OP_LH    = 6'd12,
      OP_LW    = 6'd13,
      OP_LBU   = 6'd14,
      OP_LHU   = 6'd15,
      OP_SB    = 6'd16,
      OP_SH    = 6'd17,
      OP_SW    = 6'd18,
      OP_ADDI  = 6'd19,
      OP_SLTI  = 6'd20,
      OP_SLTIU = 6'd21,
      OP_XORI  = 6'd22,
      OP_ORI   = 6'd23,
      OP_ANDI  = 6'd24,
      OP_SLLI  = 6'd25,
      OP_SRLI  = 6'd26,
      OP_SRAI  = 6'd27,
      OP_ADD   = 6'd28,
      OP_SUB   = 6'd29,
      OP_SLL   = 6'd30,
      OP_SLT   = 6'd31,
      OP_SLTU  = 6'd32,
      OP_XOR   = 6'd33,
      OP_SRL   = 6'd34,
      OP_SRA   = 6'd35,
      OP_OR    = 6'd36,
      OP_AND   = 6'd37
   } op_e;

   function automatic logic is_branch(logic [OP_W-1:0] op);
      return op >= OP_BEQ && op <= OP_BGEU;
   endfunction

   function automatic logic is_store(logic [OP_W-1:0] op);
      return op >= OP_SB && op <= OP_SW;
   endfunction

   function automatic logic has_rs2(logic [OP_W-1:0] op);
      return is_branch(op) || is_store(op) ||
             (op >= OP_ADD && op <= OP_AND);
   endfunction

   function automatic logic has_rs1(logic [OP_W-1:0] op);
      return !(op == OP_NOP || op == OP_LUI ||
               op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic writes_rd(logic [OP_W-1:0] op);
      return !(op == OP_NOP || is_branch(op) || is_store(op));
   endfunction

endpackage

// File: rtl/dispatcher_reg_status_file.sv
// Architectural register file plus rename tag table, with
// same-cycle commit bypass on both read ports.
module reg_status_file
   import dispatcher_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_W,
   parameter int ID_WIDTH  = ID_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 flush_i,
   input  logic [4:0]           rd_idx_i [2],
   output logic [ID_WIDTH-1:0]  rd_val_o [2],
   output logic [ROB_WIDTH-1:0] rd_tag_o [2],
   input  logic                 cm_en_i,
   input  logic [4:0]           cm_rd_i,
   input  logic [ROB_WIDTH-1:0] cm_tag_i,
   input  logic [ID_WIDTH-1:0]  cm_val_i,
   input  logic                 rn_en_i,
   input  logic [4:0]           rn_rd_i,
   input  logic [ROB_WIDTH-1:0] rn_tag_i
);

   logic [ID_WIDTH-1:0]  regs_q [32];
   logic [ID_WIDTH-1:0]  regs_d [32];
   logic [ROB_WIDTH-1:0] tags_q [32];
   logic [ROB_WIDTH-1:0] tags_d [32];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_tag_o[p] = tags_q[rd_idx_i[p]];
         rd_val_o[p] = regs_q[rd_idx_i[p]];
         if (rd_idx_i[p] == 5'd0) begin
            rd_tag_o[p] = '0;
            rd_val_o[p] = '0;
         end else if (cm_en_i && tags_q[rd_idx_i[p]] == '0 &&
                      cm_rd_i == rd_idx_i[p]) begin
            rd_val_o[p] = cm_val_i;
         end else if (cm_en_i && tags_q[rd_idx_i[p]] != '0 &&
                      tags_q[rd_idx_i[p]] == cm_tag_i) begin
            rd_val_o[p] = cm_val_i;
            rd_tag_o[p] = '0;
         end
      end
   end

   // Rename is applied last so it wins over a same-rd commit clear.
   always_comb begin
      regs_d = regs_q;
      tags_d = tags_q;
      if (flush_i) begin
         for (int i = 0; i < 32; i++) tags_d[i] = '0;
      end
      if (cm_en_i && cm_rd_i != 5'd0) begin
         regs_d[cm_rd_i] = cm_val_i;
         if (tags_q[cm_rd_i] == cm_tag_i) tags_d[cm_rd_i] = '0;
      end
      if (rn_en_i && rn_rd_i != 5'd0) tags_d[rn_rd_i] = rn_tag_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
            tags_q[i] <= '0;
         end
      end else if (en_i) begin
         regs_q <= regs_d;
         tags_q <= tags_d;
      end
   end

endmodule

// File: rtl/dispatcher.sv
// Issue stage: single issue slot, ROB tag allocation and operand
// resolution through CDB / ROB / commit forwarding.
module dispatcher
   import dispatcher_pkg::*;
#(
   parameter int ROB_WIDTH  = ROB_W,
   parameter int ID_WIDTH   = ID_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int OP_WIDTH   = OP_W
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  instqueue_dispatcher_en_in,
   input  logic [OP_WIDTH-1:0]   instqueue_dispatcher_opcode_in,
   input  logic [4:0]            instqueue_dispatcher_rd_in,
   input  logic [4:0]            instqueue_dispatcher_rs1_in,
   input  logic [4:0]            instqueue_dispatcher_rs2_in,
   input  logic [ID_WIDTH-1:0]   instqueue_dispatcher_imm_in,
   input  logic [ADDR_WIDTH-1:0] instqueue_dispatcher_pc_in,
   output logic                  dispatcher_instqueue_rdy_out,
   input  logic                  rs_dispatcher_rdy_in,
   output logic                  dispatcher_rs_en_out,
   output logic [ID_WIDTH-1:0]   dispatcher_rs_a_out,
   output logic [ID_WIDTH-1:0]   dispatcher_rs_vj_out,
   output logic [ID_WIDTH-1:0]   dispatcher_rs_vk_out,
   output logic [ROB_WIDTH-1:0]  dispatcher_rs_qj_out,
   output logic [ROB_WIDTH-1:0]  dispatcher_rs_qk_out,
   output logic [ROB_WIDTH-1:0]  dispatcher_rs_dest_out,
   output logic [ADDR_WIDTH-1:0] dispatcher_rs_pc_out,
   output logic [OP_WIDTH-1:0]   dispatcher_rs_opcode_out,
   input  logic                  rob_dispatcher_rdy_in,
   input  logic [ROB_WIDTH-1:0]  rob_dispatcher_tag_in,
   output logic                  dispatcher_rob_en_out,
   output logic [4:0]            dispatcher_rob_rd_out,
   output logic [OP_WIDTH-1:0]   dispatcher_rob_opcode_out,
   output logic [ADDR_WIDTH-1:0] dispatcher_rob_pc_out,
   output logic [ROB_WIDTH-1:0]  dispatcher_rob_qj_out,
   output logic [ROB_WIDTH-1:0]  dispatcher_rob_qk_out,
   input  logic                  rob_dispatcher_vj_rdy_in,
   input  logic                  rob_dispatcher_vk_rdy_in,
   input  logic [ID_WIDTH-1:0]   rob_dispatcher_vj_in,
   input  logic [ID_WIDTH-1:0]   rob_dispatcher_vk_in,
   input  logic                  rob_commit_en_in,
   input  logic [4:0]            rob_commit_rd_in,
   input  logic [ROB_WIDTH-1:0]  rob_commit_tag_in,
   input  logic [ID_WIDTH-1:0]   rob_commit_value_in,
   input  logic                  rob_rst_in,
   input  logic [ROB_WIDTH-1:0]  cdb_alu_b_in,
   input  logic [ROB_WIDTH-1:0]  cdb_lbuffer_b_in,
   input  logic [ID_WIDTH-1:0]   cdb_alu_result_in,
   input  logic [ID_WIDTH-1:0]   cdb_lbuffer_result_in
);

   logic                  slot_v_q, slot_v_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic [4:0]            rd_q, rd_d;
   logic [4:0]            rs1_q, rs1_d;
   logic [4:0]            rs2_q, rs2_d;
   logic [ID_WIDTH-1:0]   imm_q, imm_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;

   logic       fire, accept, load, flush;
   logic [4:0] rd_eff;

   logic [4:0]           ridx [2];
   logic [ID_WIDTH-1:0]  rval [2];
   logic [ROB_WIDTH-1:0] rtag [2];
   logic [ID_WIDTH-1:0]  rob_v [2];
   logic                 rob_r [2];
   logic [ID_WIDTH-1:0]  opv [2];
   logic [ROB_WIDTH-1:0] opq [2];

   assign flush  = rob_rst_in & rdy_in;
   assign fire   = slot_v_q & rs_dispatcher_rdy_in &
                   rob_dispatcher_rdy_in & !rob_rst_in &
                   rdy_in & !rst_in;
   assign accept = rdy_in & !rob_rst_in & !rst_in &
                   (!slot_v_q | fire);
   assign load   = accept & instqueue_dispatcher_en_in;
   assign rd_eff = writes_rd(op_q) ? rd_q : 5'd0;

   assign dispatcher_instqueue_rdy_out = accept;

   always_comb begin
      slot_v_d = slot_v_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      pc_d     = pc_q;
      if (load) begin
         slot_v_d = 1'b1;
         op_d     = instqueue_dispatcher_opcode_in;
         rd_d     = instqueue_dispatcher_rd_in;
         rs1_d    = instqueue_dispatcher_rs1_in;
         rs2_d    = instqueue_dispatcher_rs2_in;
         imm_d    = instqueue_dispatcher_imm_in;
         pc_d     = instqueue_dispatcher_pc_in;
      end else if (fire || flush) begin
         slot_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         slot_v_q <= 1'b0;
         op_q     <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         pc_q     <= '0;
      end else if (rdy_in) begin
         slot_v_q <= slot_v_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         pc_q     <= pc_d;
      end
   end

   assign ridx[0]  = rs1_q;
   assign ridx[1]  = rs2_q;
   assign rob_v[0] = rob_dispatcher_vj_in;
   assign rob_v[1] = rob_dispatcher_vk_in;
   assign rob_r[0] = rob_dispatcher_vj_rdy_in;
   assign rob_r[1] = rob_dispatcher_vk_rdy_in;

   reg_status_file #(
      .ROB_WIDTH (ROB_WIDTH),
      .ID_WIDTH  (ID_WIDTH)
   ) u_rsf (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .en_i     (rdy_in),
      .flush_i  (rob_rst_in),
      .rd_idx_i (ridx),
      .rd_val_o (rval),
      .rd_tag_o (rtag),
      .cm_en_i  (rob_commit_en_in),
      .cm_rd_i  (rob_commit_rd_in),
      .cm_tag_i (rob_commit_tag_in),
      .cm_val_i (rob_commit_value_in),
      .rn_en_i  (fire),
      .rn_rd_i  (rd_eff),
      .rn_tag_i (rob_dispatcher_tag_in)
   );

   // A pending tag is cleared by any same-cycle broadcast so the RS
   // never latches a tag whose result it has already missed.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         opv[p] = rval[p];
         opq[p] = rtag[p];
         if (rtag[p] != '0) begin
            if (cdb_alu_b_in == rtag[p]) begin
               opv[p] = cdb_alu_result_in;
               opq[p] = '0;
            end else if (cdb_lbuffer_b_in == rtag[p]) begin
               opv[p] = cdb_lbuffer_result_in;
               opq[p] = '0;
            end else if (rob_r[p]) begin
               opv[p] = rob_v[p];
               opq[p] = '0;
            end else begin
               opv[p] = '0;
            end
         end
      end
      if (!has_rs1(op_q)) begin
         opv[0] = '0;
         opq[0] = '0;
      end
      if (!has_rs2(op_q)) begin
         opv[1] = '0;
         opq[1] = '0;
      end
   end

   assign dispatcher_rs_en_out      = fire;
   assign dispatcher_rs_a_out       = imm_q;
   assign dispatcher_rs_vj_out      = opv[0];
   assign dispatcher_rs_vk_out      = opv[1];
   assign dispatcher_rs_qj_out      = opq[0];
   assign dispatcher_rs_qk_out      = opq[1];
   assign dispatcher_rs_dest_out    = rob_dispatcher_tag_in;
   assign dispatcher_rs_pc_out      = pc_q;
   assign dispatcher_rs_opcode_out  = op_q;

   assign dispatcher_rob_en_out     = fire;
   assign dispatcher_rob_rd_out     = rd_eff;
   assign dispatcher_rob_opcode_out = op_q;
   assign dispatcher_rob_pc_out     = pc_q;
   assign dispatcher_rob_qj_out     = rtag[0];
   assign dispatcher_rob_qk_out     = rtag[1];

endmodule

// File: tb/tb_dispatcher.sv
// Scoreboard bench for the dispatcher issue stage.
module tb_dispatcher;
   import dispatcher_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        iq_en;
   logic [5:0]  iq_op;
   logic [4:0]  iq_rd, iq_rs1, iq_rs2;
   logic [31:0] iq_imm, iq_pc;
   logic        iq_rdy;
   logic        rs_rdy, rs_en;
   logic [31:0] rs_a, rs_vj, rs_vk, rs_pc;
   logic [3:0]  rs_qj, rs_qk, rs_dest;
   logic [5:0]  rs_op;
   logic        rob_rdy, rob_en;
   logic [3:0]  rob_tag;
   logic [4:0]  rob_rd;
   logic [5:0]  rob_op;
   logic [31:0] rob_pc;
   logic [3:0]  rob_qj, rob_qk;
   logic        rob_vj_rdy, rob_vk_rdy;
   logic [31:0] rob_vj, rob_vk;
   logic        cm_en;
   logic [4:0]  cm_rd;
   logic [3:0]  cm_tag;
   logic [31:0] cm_val;
   logic        rob_rst;
   logic [3:0]  alu_b, lb_b;
   logic [31:0] alu_r, lb_r;

   always #5 clk = ~clk;

   dispatcher dut (
      .clk_in                         (clk),
      .rst_in                         (rst),
      .rdy_in                         (rdy),
      .instqueue_dispatcher_en_in     (iq_en),
      .instqueue_dispatcher_opcode_in (iq_op),
      .instqueue_dispatcher_rd_in     (iq_rd),
      .instqueue_dispatcher_rs1_in    (iq_rs1),
      .instqueue_dispatcher_rs2_in    (iq_rs2),
      .instqueue_dispatcher_imm_in    (iq_imm),
      .instqueue_dispatcher_pc_in     (iq_pc),
      .dispatcher_instqueue_rdy_out   (iq_rdy),
      .rs_dispatcher_rdy_in           (rs_rdy),
      .dispatcher_rs_en_out           (rs_en),
      .dispatcher_rs_a_out            (rs_a),
      .dispatcher_rs_vj_out           (rs_vj),
      .dispatcher_rs_vk_out           (rs_vk),
      .dispatcher_rs_qj_out           (rs_qj),
      .dispatcher_rs_qk_out           (rs_qk),
      .dispatcher_rs_dest_out         (rs_dest),
      .dispatcher_rs_pc_out           (rs_pc),
      .dispatcher_rs_opcode_out       (rs_op),
      .rob_dispatcher_rdy_in          (rob_rdy),
      .rob_dispatcher_tag_in          (rob_tag),
      .dispatcher_rob_en_out          (rob_en),
      .dispatcher_rob_rd_out          (rob_rd),
      .dispatcher_rob_opcode_out      (rob_op),
      .dispatcher_rob_pc_out          (rob_pc),
      .dispatcher_rob_qj_out          (rob_qj),
      .dispatcher_rob_qk_out          (rob_qk),
      .rob_dispatcher_vj_rdy_in       (rob_vj_rdy),
      .rob_dispatcher_vk_rdy_in       (rob_vk_rdy),
      .rob_dispatcher_vj_in           (rob_vj),
      .rob_dispatcher_vk_in           (rob_vk),
      .rob_commit_en_in               (cm_en),
      .rob_commit_rd_in               (cm_rd),
      .rob_commit_tag_in              (cm_tag),
      .rob_commit_value_in            (cm_val),
      .rob_rst_in                     (rob_rst),
      .cdb_alu_b_in                   (alu_b),
      .cdb_lbuffer_b_in               (lb_b),
      .cdb_alu_result_in              (alu_r),
      .cdb_lbuffer_result_in          (lb_r)
   );

   typedef struct {
      logic [3:0]  qj, qk, dest;
      logic [31:0] vj, vk, a, pc;
      logic [4:0]  rd;
      logic [5:0]  op;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pc_ctr   = 32'h1000;

   task automatic chk(input string name,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t",
                  name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && rs_en === 1'b1) begin
         chk("rob_en", {63'd0, rob_en}, 64'd1);
         if (sb.size() == 0) begin
            chk("unexpected_fire", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("qj",   {60'd0, rs_qj},   {60'd0, mon_e.qj});
            chk("vj",   {32'd0, rs_vj},   {32'd0, mon_e.vj});
            chk("qk",   {60'd0, rs_qk},   {60'd0, mon_e.qk});
            chk("vk",   {32'd0, rs_vk},   {32'd0, mon_e.vk});
            chk("a",    {32'd0, rs_a},    {32'd0, mon_e.a});
            chk("dest", {60'd0, rs_dest}, {60'd0, mon_e.dest});
            chk("rob_rd", {59'd0, rob_rd}, {59'd0, mon_e.rd});
            chk("rs_pc",  {32'd0, rs_pc},  {32'd0, mon_e.pc});
            chk("rob_pc", {32'd0, rob_pc}, {32'd0, mon_e.pc});
            chk("rs_op",  {58'd0, rs_op},  {58'd0, mon_e.op});
            chk("rob_op", {58'd0, rob_op}, {58'd0, mon_e.op});
         end
      end
   end

   task automatic clr_fwd();
      alu_b = '0; lb_b = '0; alu_r = '0; lb_r = '0;
      rob_vj_rdy = 0; rob_vk_rdy = 0; rob_vj = '0; rob_vk = '0;
      cm_en = 0; cm_rd = '0; cm_tag = '0; cm_val = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clr_fwd();
   endtask

   // expect: push a scoreboard entry keyed to the next issued pc
   task automatic expect_fire(input logic [3:0] qj,
                              input logic [31:0] vj,
                              input logic [3:0] qk,
                              input logic [31:0] vk,
                              input logic [31:0] a,
                              input logic [3:0] dest,
                              input logic [4:0] rd,
                              input logic [5:0] op);
      exp_t e;
      e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
      e.a = a; e.dest = dest; e.rd = rd; e.op = op;
      e.pc = pc_ctr;
      sb.push_back(e);
   endtask

   // Returns one cycle after the load edge, i.e. in the fire cycle.
   task automatic issue(input logic [5:0] op,
                        input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2,
                        input logic [31:0] imm,
                        input logic [3:0] tag);
      bit done = 0;
      iq_en = 1; iq_op = op; iq_rd = rd;
      iq_rs1 = rs1; iq_rs2 = rs2; iq_imm = imm;
      iq_pc = pc_ctr;
      for (int i = 0; i < 20 && !done; i++) begin
         if (iq_rdy === 1'b1) done = 1;
         @(posedge clk);
         #1;
      end
      iq_en = 0;
      pc_ctr += 4;
      rob_tag = tag;
      if (!done) chk("issue_load_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      rst = 1; rdy = 1; iq_en = 0;
      iq_op = '0; iq_rd = '0; iq_rs1 = '0; iq_rs2 = '0;
      iq_imm = '0; iq_pc = '0;
      rs_rdy = 1; rob_rdy = 1; rob_tag = 4'd1; rob_rst = 0;
      clr_fwd();
      repeat (2) @(negedge clk);
      chk("rst_iq_rdy", {63'd0, iq_rdy}, 64'd0);
      chk("rst_rs_en",  {63'd0, rs_en},  64'd0);
      chk("rst_rob_en", {63'd0, rob_en}, 64'd0);
      rst = 0;
      #1;
      chk("post_rst_iq_rdy", {63'd0, iq_rdy}, 64'd1);

      // ADDI x1,x0,5 -> tag 3
      expect_fire(0, 0, 0, 0, 5, 3, 1, OP_ADDI);
      issue(OP_ADDI, 1, 0, 0, 5, 3);
      tick();
      @(negedge clk);
      chk("en_one_cycle", {63'd0, rs_en}, 64'd0);

      // ADD x2,x1,x1 while tag 3 pending
      expect_fire(3, 0, 3, 0, 0, 4, 2, OP_ADD);
      issue(OP_ADD, 2, 1, 1, 0, 4);
      @(negedge clk);
      chk("rob_qj_lookup", {60'd0, rob_qj}, 64'd3);
      tick();

      // same, with ALU broadcast of tag 3 in the issue cycle
      expect_fire(0, 9, 0, 9, 0, 5, 2, OP_ADD);
      issue(OP_ADD, 2, 1, 1, 0, 5);
      alu_b = 3; alu_r = 9;
      tick();

      // commit x1 (tag 3, 9) while renaming x1 to tag 6
      expect_fire(0, 9, 0, 0, 1, 6, 1, OP_ADDI);
      issue(OP_ADDI, 1, 1, 0, 1, 6);
      cm_en = 1; cm_rd = 1; cm_tag = 3; cm_val = 9;
      tick();

      // ROB full for three cycles, x1 must now carry tag 6
      expect_fire(6, 0, 0, 0, 0, 7, 3, OP_ADD);
      issue(OP_ADD, 3, 1, 0, 0, 7);
      rob_rdy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rs_en",  {63'd0, rs_en},  64'd0);
         chk("stall_iq_rdy", {63'd0, iq_rdy}, 64'd0);
         tick();
      end
      rob_rdy = 1;
      tick();

      // flush with a full slot: nothing may issue
      issue(OP_ADDI, 4, 0, 0, 2, 8);
      rob_rst = 1;
      @(negedge clk);
      chk("flush_rs_en",  {63'd0, rs_en},  64'd0);
      chk("flush_iq_rdy", {63'd0, iq_rdy}, 64'd0);
      tick();
      rob_rst = 0;
      @(negedge clk);
      chk("post_flush_rs_en",  {63'd0, rs_en},  64'd0);
      chk("post_flush_iq_rdy", {63'd0, iq_rdy}, 64'd1);

      // tags cleared, regfile kept: x1=9, x2=0
      expect_fire(0, 9, 0, 0, 0, 9, 5, OP_ADD);
      issue(OP_ADD, 5, 1, 2, 0, 9);
      tick();

      expect_fire(0, 0, 0, 0, 3, 10, 1, OP_ADDI);
      issue(OP_ADDI, 1, 0, 0, 3, 10);
      tick();

      // SW x1,4(x2): x2 gets same-cycle commit value 20
      expect_fire(0, 20, 10, 0, 4, 11, 0, OP_SW);
      issue(OP_SW, 2, 2, 1, 4, 11);
      cm_en = 1; cm_rd = 2; cm_tag = 5; cm_val = 20;
      @(negedge clk);
      chk("sw_rob_qk", {60'd0, rob_qk}, 64'd10);
      tick();

      // store did not rename x2
      expect_fire(0, 20, 10, 0, 0, 12, 7, OP_ADD);
      issue(OP_ADD, 7, 2, 1, 0, 12);
      tick();

      expect_fire(0, 33, 0, 33, 0, 13, 8, OP_ADD);
      issue(OP_ADD, 8, 1, 1, 0, 13);
      lb_b = 10; lb_r = 33;
      tick();

      // ALU broadcast has priority over load buffer
      expect_fire(0, 50, 0, 50, 0, 14, 11, OP_ADD);
      issue(OP_ADD, 11, 1, 1, 0, 14);
      alu_b = 10; alu_r = 50; lb_b = 10; lb_r = 33;
      tick();

      // ROB value path; rs2 field ignored for I-type
      expect_fire(0, 44, 0, 0, 0, 15, 9, OP_ADDI);
      issue(OP_ADDI, 9, 1, 1, 0, 15);
      rob_vj_rdy = 1; rob_vj = 44; rob_vk_rdy = 1; rob_vk = 77;
      @(negedge clk);
      chk("rob_qj_x1", {60'd0, rob_qj}, 64'd10);
      tick();

      // LUI ignores both source fields
      expect_fire(0, 0, 0, 0, 32'h12345000, 1, 10, OP_LUI);
      issue(OP_LUI, 10, 1, 1, 32'h12345000, 1);
      tick();

      // global enable low freezes everything
      expect_fire(10, 0, 0, 0, 0, 2, 12, OP_ADD);
      issue(OP_ADD, 12, 1, 0, 0, 2);
      rdy = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rdy_low_rs_en",  {63'd0, rs_en},  64'd0);
         chk("rdy_low_iq_rdy", {63'd0, iq_rdy}, 64'd0);
         tick();
      end
      rdy = 1;
      tick();

      repeat (3) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
